// File: rtl/note_judge_pkg.sv
// Shared definitions for the rhythm judge: verdict encoding, FSM states and
// score defaults that downstream BCD width checks reuse.
package note_judge_pkg;

    typedef enum logic [1:0] {
        JUDGE_NONE    = 2'd0,
        JUDGE_PERFECT = 2'd1,
        JUDGE_GOOD    = 2'd2,
        JUDGE_MISS    = 2'd3
    } judge_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned SCORE_W         = 20;
    localparam int unsigned SCORE_MAX_DEF   = 999999;
    localparam int unsigned PERFECT_PTS_DEF = 10;
    localparam int unsigned GOOD_PTS_DEF    = 5;

endpackage

// File: rtl/note_judge_sat.sv
// Saturating adder: acc + add computed one bit wider, clamped to MAX.
module sat_accum #(
    parameter int unsigned W   = 8,
    parameter int unsigned AW  = 1,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic [W-1:0]  acc,
    input  logic [AW-1:0] add,
    output logic [W-1:0]  sum
);

    logic [W:0] add_ext;
    logic [W:0] sum_wide;

    always_comb begin
        add_ext  = (W+1)'(add);
        sum_wide = {1'b0, acc} + add_ext;
        if (sum_wide > {1'b0, MAX}) begin
            sum = MAX;
        end else begin
            sum = sum_wide[W-1:0];
        end
    end

endmodule

// File: rtl/note_judge.sv
// Judges the first key press per score note as PERFECT/GOOD/MISS and keeps
// saturating score, combo and hit/miss counters.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int unsigned PERFECT_MS  = 100,
    parameter int unsigned GOOD_MS     = 250,
    parameter int unsigned PERFECT_PTS = PERFECT_PTS_DEF,
    parameter int unsigned GOOD_PTS    = GOOD_PTS_DEF,
    parameter int unsigned COMBO_CAP   = 10,
    parameter int unsigned SCORE_MAX   = SCORE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1ms,
    input  logic        en,
    input  logic [7:0]  note_pointer,
    input  logic [3:0]  cur_note,
    input  logic [3:0]  cur_octave,
    input  logic [3:0]  in_note,
    input  logic [3:0]  in_octave,
    input  logic        key_level,
    output logic [19:0] score,
    output logic [9:0]  combo,
    output logic [9:0]  max_combo,
    output logic [7:0]  hits,
    output logic [7:0]  misses,
    output logic [1:0]  judge,
    output logic        judge_valid
);

    state_t      state_q, state_d, note_state;
    judge_t      judge_q, judge_d, verdict;
    logic [7:0]  ptr_q;
    logic        key_q;
    logic [15:0] el_ms, el_eff;

    logic        press, new_note, old_miss, pitch_ok, judged, hit, press_miss, pulse;
    logic [9:0]  combo_base, combo_up, combo_d, max_combo_d;
    logic [31:0] combo_ext, bonus, base_pts;
    logic [19:0] score_add, score_sum;
    logic [1:0]  miss_add;
    logic [7:0]  hits_sum, misses_sum;

    assign press    = key_level & ~key_q;
    assign new_note = (note_pointer != ptr_q);
    assign pitch_ok = (in_note == cur_note) && (in_octave == cur_octave);
    assign judge    = judge_q;

    // A pointer change resolves the old note first; the press then sees the new note at 0 ms.
    always_comb begin
        old_miss   = new_note && (state_q == ST_ARMED);
        note_state = state_q;
        el_eff     = el_ms;
        if (new_note) begin
            note_state = (cur_note != '0) ? ST_ARMED : ST_DONE;
            el_eff     = '0;
        end
        judged = press && (note_state == ST_ARMED);
    end

    always_comb begin
        verdict = JUDGE_MISS;
        if (pitch_ok) begin
            if ({16'd0, el_eff} <= PERFECT_MS) begin
                verdict = JUDGE_PERFECT;
            end else if ({16'd0, el_eff} <= GOOD_MS) begin
                verdict = JUDGE_GOOD;
            end
        end
    end

    // Next-state and verdict selection.
    always_comb begin
        state_d = note_state;
        judge_d = judge_q;
        pulse   = 1'b0;
        if (judged) begin
            state_d = ST_DONE;
            judge_d = verdict;
            pulse   = 1'b1;
        end else if (old_miss) begin
            judge_d = JUDGE_MISS;
            pulse   = 1'b1;
        end
        if (!en) begin
            state_d = state_q;
            judge_d = judge_q;
            pulse   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        hit        = judged && (verdict != JUDGE_MISS);
        press_miss = judged && (verdict == JUDGE_MISS);
        combo_base = old_miss ? '0 : combo;
        combo_ext  = {22'd0, combo_base};
        bonus      = (combo_ext > COMBO_CAP) ? COMBO_CAP : combo_ext;
        base_pts   = (verdict == JUDGE_PERFECT) ? PERFECT_PTS : GOOD_PTS;
        score_add  = hit ? 20'(base_pts + bonus) : '0;
        miss_add   = {1'b0, old_miss} + {1'b0, press_miss};
        combo_d    = combo_base;
        if (hit) begin
            combo_d = combo_up;
        end else if (press_miss) begin
            combo_d = '0;
        end
        max_combo_d = max_combo;
        if (hit && (combo_up > max_combo)) begin
            max_combo_d = combo_up;
        end
    end

    sat_accum #(.W(20), .AW(20), .MAX(20'(SCORE_MAX))) u_score (
        .acc(score), .add(score_add), .sum(score_sum)
    );

    sat_accum #(.W(10), .AW(1), .MAX(10'h3FF)) u_combo (
        .acc(combo_base), .add(1'b1), .sum(combo_up)
    );

    sat_accum #(.W(8), .AW(1), .MAX(8'hFF)) u_hits (
        .acc(hits), .add(hit), .sum(hits_sum)
    );

    sat_accum #(.W(8), .AW(2), .MAX(8'hFF)) u_misses (
        .acc(misses), .add(miss_add), .sum(misses_sum)
    );

    // Edge/pointer trackers follow their inputs even when disabled or in reset.
    always_ff @(posedge clk) begin
        ptr_q <= note_pointer;
        key_q <= key_level;
        if (rst) begin
            el_ms       <= '0;
            score       <= '0;
            combo       <= '0;
            max_combo   <= '0;
            hits        <= '0;
            misses      <= '0;
            judge_q     <= JUDGE_NONE;
            judge_valid <= 1'b0;
        end else begin
            judge_q     <= judge_d;
            judge_valid <= pulse;
            if (en) begin
                if (new_note) begin
                    el_ms <= '0;
                end else if (tick_1ms && (el_ms != '1)) begin
                    el_ms <= el_ms + 16'd1;
                end
                score     <= score_sum;
                combo     <= combo_d;
                max_combo <= max_combo_d;
                hits      <= hits_sum;
                misses    <= misses_sum;
            end
        end
    end

endmodule

// File: tb/tb_note_judge.sv
// Bench for note_judge: directed table, hand sequences and random stimulus
// against an event-level reference model.
module tb_note_judge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tick_1ms, en, key_level;
    logic [7:0]  note_pointer;
    logic [3:0]  cur_note, cur_octave, in_note, in_octave;
    logic [19:0] score, s_score;
    logic [9:0]  combo, max_combo, s_combo, s_max_combo;
    logic [7:0]  hits, misses, s_hits, s_misses;
    logic [1:0]  judge, s_judge;
    logic        judge_valid, s_judge_valid;

    note_judge dut (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .en(en),
        .note_pointer(note_pointer), .cur_note(cur_note), .cur_octave(cur_octave),
        .in_note(in_note), .in_octave(in_octave), .key_level(key_level),
        .score(score), .combo(combo), .max_combo(max_combo),
        .hits(hits), .misses(misses), .judge(judge), .judge_valid(judge_valid)
    );

    // Small score ceiling so the clamp is exercised within a short run.
    note_judge #(.SCORE_MAX(30)) dut_sat (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .en(en),
        .note_pointer(note_pointer), .cur_note(cur_note), .cur_octave(cur_octave),
        .in_note(in_note), .in_octave(in_octave), .key_level(key_level),
        .score(s_score), .combo(s_combo), .max_combo(s_max_combo),
        .hits(s_hits), .misses(s_misses), .judge(s_judge), .judge_valid(s_judge_valid)
    );

    int checks = 0;
    int errors = 0;

    int     m_ptr, m_key, m_el, m_combo, m_maxc, m_hits, m_misses, m_judge;
    bit     m_open, m_jv;
    longint m_score;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_miss();
        m_combo  = 0;
        m_misses = (m_misses < 255) ? m_misses + 1 : 255;
    endfunction

    // Applies the rules for one clock using the inputs about to be sampled.
    function automatic void model_apply();
        bit press, newn;
        int v;
        if (rst) begin
            m_ptr = note_pointer; m_key = key_level; m_open = 0; m_el = 0;
            m_score = 0; m_combo = 0; m_maxc = 0; m_hits = 0; m_misses = 0;
            m_judge = 0; m_jv = 0;
            return;
        end
        press = key_level && (m_key == 0);
        newn  = (note_pointer != m_ptr);
        m_ptr = note_pointer;
        m_key = key_level;
        m_jv  = 0;
        if (!en) return;
        if (newn) begin
            if (m_open) begin
                model_miss();
                m_judge = 3;
                m_jv = 1;
            end
            m_open = (cur_note != 0);
            m_el = 0;
        end
        if (press && m_open) begin
            m_open = 0;
            m_jv = 1;
            if (in_note != cur_note || in_octave != cur_octave || m_el > 250) v = 3;
            else if (m_el <= 100) v = 1;
            else v = 2;
            m_judge = v;
            if (v == 3) begin
                model_miss();
            end else begin
                m_score += ((v == 1) ? 10 : 5) + ((m_combo < 10) ? m_combo : 10);
                m_combo = (m_combo < 1023) ? m_combo + 1 : 1023;
                m_hits  = (m_hits < 255) ? m_hits + 1 : 255;
                if (m_combo > m_maxc) m_maxc = m_combo;
            end
        end
        if (!newn && tick_1ms && m_el < 65535) m_el++;
    endfunction

    task automatic compare_all();
        check("score",       32'(score),     32'((m_score > 999999) ? 999999 : m_score));
        check("sat_score",   32'(s_score),   32'((m_score > 30) ? 30 : m_score));
        check("combo",       32'(combo),     32'(m_combo));
        check("max_combo",   32'(max_combo), 32'(m_maxc));
        check("hits",        32'(hits),      32'(m_hits));
        check("misses",      32'(misses),    32'(m_misses));
        check("judge",       32'(judge),     32'(m_judge));
        check("judge_valid", 32'(judge_valid), 32'(m_jv));
    endtask

    task automatic step();
        model_apply();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        int ptr; int note; int oct; int ticks; int pnote; int poct;
        int e_judge; int e_score; int e_combo; int e_maxc; int e_hits; int e_misses;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1,  5, 4, 50,  5, 4, 1, 10, 1, 1, 1, 0};
        tbl[1] = '{2,  5, 4, 0,   5, 4, 1, 21, 2, 2, 2, 0};
        tbl[2] = '{3,  5, 4, 0,   5, 4, 1, 33, 3, 3, 3, 0};
        tbl[3] = '{4,  5, 4, 200, 5, 4, 2, 41, 4, 4, 4, 0};
        tbl[4] = '{5,  5, 4, 10,  6, 4, 3, 41, 0, 4, 4, 1};
        tbl[5] = '{6,  5, 4, 300, 5, 4, 3, 41, 0, 4, 4, 2};
        tbl[6] = '{7,  3, 5, 100, 3, 5, 1, 51, 1, 4, 5, 2};
        tbl[7] = '{8,  3, 5, 250, 3, 5, 2, 57, 2, 4, 6, 2};
        tbl[8] = '{9,  3, 5, 101, 3, 5, 2, 64, 3, 4, 7, 2};
        tbl[9] = '{10, 3, 5, 251, 3, 5, 3, 64, 0, 4, 7, 3};

        rst = 1'b1; en = 1'b1; tick_1ms = 1'b0; key_level = 1'b0;
        note_pointer = 8'd0; cur_note = 4'd0; cur_octave = 4'd0;
        in_note = 4'd0; in_octave = 4'd0;
        step(); step();
        check("reset_score", 32'(score), 0);
        check("reset_judge", 32'(judge), 0);
        rst = 1'b0;
        step();

        foreach (tbl[i]) begin
            note_pointer = 8'(tbl[i].ptr); cur_note = 4'(tbl[i].note); cur_octave = 4'(tbl[i].oct);
            key_level = 1'b0; tick_1ms = 1'b0;
            step();
            repeat (tbl[i].ticks) begin tick_1ms = 1'b1; step(); end
            tick_1ms = 1'b0;
            in_note = 4'(tbl[i].pnote); in_octave = 4'(tbl[i].poct); key_level = 1'b1;
            step();
            check("tbl_valid",  32'(judge_valid), 1);
            check("tbl_judge",  32'(judge),     32'(tbl[i].e_judge));
            check("tbl_score",  32'(score),     32'(tbl[i].e_score));
            check("tbl_combo",  32'(combo),     32'(tbl[i].e_combo));
            check("tbl_maxc",   32'(max_combo), 32'(tbl[i].e_maxc));
            check("tbl_hits",   32'(hits),      32'(tbl[i].e_hits));
            check("tbl_misses", 32'(misses),    32'(tbl[i].e_misses));
            key_level = 1'b0;
            step();
            check("tbl_pulse_end", 32'(judge_valid), 0);
        end

        // Unpressed note missed on pointer advance; rest note and repeat press give no pulse.
        note_pointer = 8'd11; cur_note = 4'd5; cur_octave = 4'd4; step();
        note_pointer = 8'd12; cur_note = 4'd0; step();
        check("nopress_valid",  32'(judge_valid), 1);
        check("nopress_judge",  32'(judge), 3);
        check("nopress_misses", 32'(misses), 4);
        note_pointer = 8'd13; cur_note = 4'd5; step();
        check("rest_no_pulse", 32'(judge_valid), 0);
        in_note = 4'd5; in_octave = 4'd4; key_level = 1'b1; step();
        check("el0_perfect", 32'(judge), 1);
        check("el0_score",   32'(score), 74);
        key_level = 1'b0; step();
        key_level = 1'b1; step();
        check("second_press", 32'(judge_valid), 0);
        key_level = 1'b0; step();

        // Press edge coincident with pointer change away from an armed note.
        note_pointer = 8'd14; step();
        note_pointer = 8'd15; cur_note = 4'd6; cur_octave = 4'd3;
        in_note = 4'd6; in_octave = 4'd3; key_level = 1'b1; step();
        check("same_valid",  32'(judge_valid), 1);
        check("same_judge",  32'(judge), 1);
        check("same_misses", 32'(misses), 5);
        check("same_hits",   32'(hits), 9);
        check("same_combo",  32'(combo), 1);
        check("same_score",  32'(score), 84);
        key_level = 1'b0; step();

        // Reset mid-note: back to IDLE, the interrupted note is never judged.
        note_pointer = 8'd16; cur_note = 4'd5; cur_octave = 4'd4; in_note = 4'd5; in_octave = 4'd4;
        step();
        repeat (5) begin tick_1ms = 1'b1; step(); end
        tick_1ms = 1'b0; rst = 1'b1; step();
        check("rst_score",  32'(score), 0);
        check("rst_misses", 32'(misses), 0);
        check("rst_valid",  32'(judge_valid), 0);
        rst = 1'b0; key_level = 1'b1; step();
        check("idle_press", 32'(judge_valid), 0);
        key_level = 1'b0; note_pointer = 8'd17; step();
        check("idle_advance", 32'(judge_valid), 0);

        // Disabled: nothing moves, and re-enable creates no event.
        note_pointer = 8'd18; step();
        en = 1'b0;
        repeat (10) begin tick_1ms = 1'b1; step(); end
        tick_1ms = 1'b0; note_pointer = 8'd19; step();
        check("en_low_no_pulse", 32'(judge_valid), 0);
        en = 1'b1; step();
        check("reenable_no_pulse", 32'(judge_valid), 0);
        key_level = 1'b1; step();
        check("en_resume_judge", 32'(judge), 1);
        key_level = 1'b0; step();

        // Back-to-back hits drive combo and hits into saturation.
        for (int k = 0; k < 1100; k++) begin
            note_pointer = note_pointer + 8'd1; key_level = 1'b1; step();
            key_level = 1'b0; step();
        end
        check("combo_sat",     32'(combo), 1023);
        check("max_combo_sat", 32'(max_combo), 1023);
        check("hits_sat",      32'(hits), 255);
        check("score_clamp",   32'(s_score), 30);

        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 499) == 0);
            en        = ($urandom_range(0, 9) != 0);
            tick_1ms  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) < 3) key_level = ~key_level;
            if ($urandom_range(0, 9) == 0) begin
                note_pointer = 8'($urandom);
                cur_note     = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 2));
                cur_octave   = 4'd4;
            end
            if ($urandom_range(0, 9) < 7) begin
                in_note = cur_note; in_octave = cur_octave;
            end else begin
                in_note = 4'($urandom_range(1, 3)); in_octave = 4'($urandom_range(3, 4));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_judge.md
# note_judge

Rhythm-scoring stage that sits downstream of the music score controller and the keypad/keyboard note decoders and replaces the free-running `game_statistics` comparator. For every score note it judges the player's first key press as PERFECT, GOOD or MISS from pitch match and press latency. It accumulates a saturating score, combo and hit/miss counters that feed the BCD encoder and the seven-segment display.

## Interface
Parameters:
- `PERFECT_MS`, 100: max ms after note start for a PERFECT.
- `GOOD_MS`, 250: max ms after note start for a GOOD; must be ≥ `PERFECT_MS`.
- `PERFECT_PTS`, 10: base points for a PERFECT.
- `GOOD_PTS`, 5: base points for a GOOD.
- `COMBO_CAP`, 10: max combo bonus added per hit.
- `SCORE_MAX`, 999999: score saturation value; fits 6 BCD digits.

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `tick_1ms` in 1: one-`clk` pulse every ms; same source as `clk_1ms`, already synchronised to `clk`.
- `en` in 1: judging enable. Low in mute/pause mode.
- `note_pointer` in 8: index of the current score note.
- `cur_note` in 4: expected note. 0 = rest.
- `cur_octave` in 4: expected octave.
- `in_note` in 4: player note.
- `in_octave` in 4: player octave.
- `key_level` in 1: level from `ready | keypress`.
- `score` out 20: saturating score.
- `combo` out 10: current consecutive hits, saturating at 1023.
- `max_combo` out 10: best combo since reset.
- `hits` out 8, `misses` out 8: counters, saturating at 255.
- `judge` out 2: last verdict. 0 NONE, 1 PERFECT, 2 GOOD, 3 MISS.
- `judge_valid` out 1: one-cycle pulse when `judge` updates.

## Operation
- Reset: all outputs 0, `judge`=NONE, FSM=IDLE. The internal `ptr_q` loads `note_pointer` and `key_q` loads `key_level`, so reset never creates a false edge.
- Press is detected as a rising edge of `key_level`: `key_level & ~key_q`.
- New note is detected as `note_pointer != ptr_q`. On detection, `ptr_q` is updated and the elapsed counter `el_ms` (16 bit) is cleared.
- `el_ms` increments on `tick_1ms` and saturates at 0xFFFF.
- FSM states:
  - IDLE: no note judged yet.
  - ARMED: current note is non-rest and unjudged.
  - DONE: current note is judged, or is a rest.
- On new note: go to ARMED if `cur_note != 0`, else DONE. If the previous state was ARMED, the old note is judged MISS.
- Press in ARMED:
  - Pitch mismatch: MISS.
  - Pitch match and `el_ms ≤ PERFECT_MS`: PERFECT.
  - Pitch match and `el_ms ≤ GOOD_MS`: GOOD.
  - Pitch match and later: MISS.
  - After any of these, go to DONE.
- Press in DONE or IDLE is ignored.
- A hit adds `base + min(combo, COMBO_CAP)`, using `combo` before its increment. Then `combo`+1, `hits`+1, and `max_combo = max(max_combo, new combo)`.
- A MISS sets `combo`=0 and `misses`+1. Score is unchanged.
- Score adds in 21 bits and clamps to `SCORE_MAX`.
- Same cycle, new note and press: the old note is judged first (MISS if it was ARMED). The press then applies to the new note with `el_ms`=0.
  - Only the press verdict appears on `judge`.
  - Counters reflect both events in that one update.
- `en` low: FSM, counters and `el_ms` freeze. `ptr_q` and `key_q` still track their inputs, so re-enabling creates no spurious events.

## Timing
- Verdict, counters and `judge_valid` are registered one `clk` after the press edge or pointer change is sampled.
- `judge` holds its value until the next verdict.
- `rst` mid-note returns to IDLE. The current note is not judged until the next pointer change.
- `el_ms` resolution is one `tick_1ms`. The PERFECT/GOOD bounds are inclusive.

## Structure
- Shared package holds the judge encoding (`JUDGE_NONE/PERFECT/GOOD/MISS`) and the FSM state typedef.
- `SCORE_MAX` and point defaults are exported there so `bcd_encoder` width checks share them.
- One sub-module, `sat_accum`: a parameterised width/max saturating adder used for score, hits and misses.

## Test plan
- Pointer 0→1 with note 5/oct 4; press 5/4 after 50 ticks → PERFECT, score=10, combo=1, hits=1.
- Three consecutive PERFECTs starting from combo 0 → scores 10, 21, 33; max_combo=3.
- Press 5/4 at 200 ms → GOOD +5 plus bonus. Press 6/4 → MISS, combo=0, misses+1. Press at 300 ms → MISS.
- Pointer advances with no press on a non-rest note → MISS pulse one cycle later. On a rest note → no pulse. A second press on a judged note → no pulse.
- Press edge in the same cycle as a pointer change: old note ARMED → misses+1, and the new note is judged PERFECT in the same update.
- Preload score to 999995 and hit PERFECT → score=999999. Assert `rst` mid-note → all outputs 0, `judge_valid` stays low.
